// File: rtl/fb_access_sched_if.sv
// Framebuffer access scheduler bus: scan position, write FIFO head,
// framebuffer strobes and clear-sweep status.
interface fb_access_sched_if #(
    parameter int HPOS_WIDTH = 10,
    parameter int VPOS_WIDTH = 10,
    parameter int ADDR_WIDTH = 10
);
    logic                  clear_req;
    logic                  display_on;
    logic [HPOS_WIDTH-1:0] hpos;
    logic [VPOS_WIDTH-1:0] vpos;
    logic                  fifo_empty;
    logic [HPOS_WIDTH-1:0] fifo_hpos;
    logic [VPOS_WIDTH-1:0] fifo_vpos;
    logic [2:0]            fifo_rgb;
    logic                  fifo_pop;
    logic [HPOS_WIDTH-1:0] fb_hpos;
    logic [VPOS_WIDTH-1:0] fb_vpos;
    logic [2:0]            fb_rgb;
    logic                  fb_we;
    logic                  fb_clr;
    logic [ADDR_WIDTH-1:0] fb_clr_addr;
    logic                  clearing;
    logic                  clear_done;

    modport master (
        output clear_req, display_on, hpos, vpos,
        output fifo_empty, fifo_hpos, fifo_vpos, fifo_rgb,
        input  fifo_pop, fb_hpos, fb_vpos, fb_rgb,
        input  fb_we, fb_clr, fb_clr_addr,
        input  clearing, clear_done
    );

    modport slave (
        input  clear_req, display_on, hpos, vpos,
        input  fifo_empty, fifo_hpos, fifo_vpos, fifo_rgb,
        output fifo_pop, fb_hpos, fb_vpos, fb_rgb,
        output fb_we, fb_clr, fb_clr_addr,
        output clearing, clear_done
    );
endinterface

// File: rtl/fb_access_sched.sv
// Framebuffer port scheduler: display scan first, then clear sweep
// or budgeted FIFO drain during blanking.
module fb_access_sched #(
    parameter int HPOS_WIDTH = 10,
    parameter int VPOS_WIDTH = 10,
    parameter int ADDR_WIDTH = 10,
    parameter int RAMLENGTH  = 800,
    parameter int POP_LIMIT  = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    fb_access_sched_if.slave bus
);

    localparam int PCW = (POP_LIMIT > 0) ? $clog2(POP_LIMIT + 1) : 1;
    localparam logic [PCW-1:0]        LIMIT = PCW'(POP_LIMIT);
    localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(RAMLENGTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [PCW-1:0]        pop_cnt_q, pop_cnt_d;
    logic                  done_q, done_d;

    logic                  clr;
    logic                  pop;
    logic                  budget_ok;
    logic [HPOS_WIDTH-1:0] hpos_mux;
    logic [VPOS_WIDTH-1:0] vpos_mux;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
            pop_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            pop_cnt_q <= pop_cnt_d;
            done_q    <= done_d;
        end
    end

    // An unlimited budget never advances the counter.
    assign budget_ok = (POP_LIMIT == 0) || (pop_cnt_q < LIMIT);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        done_d    = 1'b0;
        clr       = 1'b0;
        pop       = 1'b0;

        unique case (state_q)
            S_CLEAR: begin
                clr = !bus.display_on;
                if (bus.clear_req) begin
                    clr_cnt_d = '0;
                end else if (clr) begin
                    if (clr_cnt_q == LAST) begin
                        state_d   = S_RUN;
                        clr_cnt_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                    end
                end
            end
            S_RUN: begin
                pop = !bus.display_on && !bus.fifo_empty && budget_ok;
                if (bus.clear_req) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = S_CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        pop_cnt_d = pop_cnt_q;
        if (bus.display_on) begin
            pop_cnt_d = '0;
        end else if (pop && (pop_cnt_q < LIMIT)) begin
            pop_cnt_d = pop_cnt_q + PCW'(1);
        end
    end

    always_comb begin
        hpos_mux = bus.fifo_hpos;
        vpos_mux = bus.fifo_vpos;
        if (bus.display_on) begin
            hpos_mux = bus.hpos;
            vpos_mux = bus.vpos;
        end
    end

    assign bus.fb_hpos     = hpos_mux;
    assign bus.fb_vpos     = vpos_mux;
    assign bus.fb_rgb      = bus.fifo_rgb;
    assign bus.fifo_pop    = pop;
    assign bus.fb_we       = pop;
    assign bus.fb_clr      = clr;
    assign bus.fb_clr_addr = clr_cnt_q;
    assign bus.clearing    = (state_q == S_CLEAR);
    assign bus.clear_done  = done_q;

    always_comb begin
        assert (!(pop && clr));
    end

endmodule

// File: tb/tb_fb_access_sched.sv
// Scoreboard bench for fb_access_sched: FIFO model feeds the DUT,
// expected framebuffer writes are queued at push and checked at write.
module tb_fb_access_sched;

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic [2:0] rgb;
    } px_t;

    logic clk;
    logic reset_n;

    fb_access_sched_if #(
        .HPOS_WIDTH(10),
        .VPOS_WIDTH(10),
        .ADDR_WIDTH(10)
    ) fb ();

    fb_access_sched #(
        .HPOS_WIDTH(10),
        .VPOS_WIDTH(10),
        .ADDR_WIDTH(10),
        .RAMLENGTH (800),
        .POP_LIMIT (5)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (fb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    px_t  fifo_q[$];
    px_t  exp_q[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   n_wr = 0;

    logic       s_clr, s_pop, s_we, s_done, s_clearing;
    logic [9:0] s_addr, s_h, s_v;
    logic [2:0] s_rgb;

    task automatic chk(string tag, int got, int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    task automatic upd_head();
        fb.fifo_empty = (fifo_q.size() == 0);
        if (fifo_q.size() != 0) begin
            fb.fifo_hpos = fifo_q[0].h;
            fb.fifo_vpos = fifo_q[0].v;
            fb.fifo_rgb  = fifo_q[0].rgb;
        end else begin
            fb.fifo_hpos = '0;
            fb.fifo_vpos = '0;
            fb.fifo_rgb  = '0;
        end
    endtask

    task automatic push(int n);
        px_t p;
        for (int i = 0; i < n; i++) begin
            p.h   = 10'($urandom_range(0, 1023));
            p.v   = 10'($urandom_range(0, 1023));
            p.rgb = 3'($urandom_range(0, 7));
            fifo_q.push_back(p);
            exp_q.push_back(p);
        end
        upd_head();
    endtask

    // One clock cycle: sample at negedge, advance FIFO after posedge.
    task automatic tick();
        px_t e;
        int  eh, ev;
        @(negedge clk);
        s_clr      = fb.fb_clr;
        s_pop      = fb.fifo_pop;
        s_we       = fb.fb_we;
        s_done     = fb.clear_done;
        s_clearing = fb.clearing;
        s_addr     = fb.fb_clr_addr;
        s_h        = fb.fb_hpos;
        s_v        = fb.fb_vpos;
        s_rgb      = fb.fb_rgb;
        eh = fb.display_on ? int'(fb.hpos) : int'(fb.fifo_hpos);
        ev = fb.display_on ? int'(fb.vpos) : int'(fb.fifo_vpos);
        chk("we_clr_excl", int'(s_we & s_clr), 0);
        chk("strobe_in_video", int'((s_we | s_clr) & fb.display_on), 0);
        chk("pop_vs_we", int'(s_pop), int'(s_we));
        chk("mux_h", int'(s_h), eh);
        chk("mux_v", int'(s_v), ev);
        chk("rgb", int'(s_rgb), int'(fb.fifo_rgb));
        if (s_we) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_h", int'(s_h), int'(e.h));
                chk("wr_v", int'(s_v), int'(e.v));
                chk("wr_rgb", int'(s_rgb), int'(e.rgb));
            end
        end
        @(posedge clk);
        #1;
        if (s_pop && fifo_q.size() != 0) e = fifo_q.pop_front();
        upd_head();
    endtask

    initial begin
        int base;
        int low_seen;
        int head_h;
        bit got_done;

        reset_n       = 1'b0;
        fb.clear_req  = 1'b0;
        fb.display_on = 1'b0;
        fb.hpos       = 10'd0;
        fb.vpos       = 10'd0;
        push(20);

        #12;
        chk("rst_clearing", int'(fb.clearing), 1);
        chk("rst_addr", int'(fb.fb_clr_addr), 0);
        chk("rst_clr", int'(fb.fb_clr), 1);
        chk("rst_pop", int'(fb.fifo_pop), 0);
        chk("rst_we", int'(fb.fb_we), 0);
        chk("rst_done", int'(fb.clear_done), 0);
        fb.display_on = 1'b1;
        fb.hpos       = 10'd37;
        #1;
        chk("rst_clr_video", int'(fb.fb_clr), 0);
        chk("rst_mux_h", int'(fb.fb_hpos), 37);
        fb.display_on = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset sweep with a non-empty FIFO
        for (int i = 0; i < 800; i++) begin
            tick();
            chk("sweep_addr", int'(s_addr), i);
            chk("sweep_clr", int'(s_clr), 1);
            chk("sweep_pop", int'(s_pop), 0);
            chk("sweep_done", int'(s_done), 0);
        end
        base = n_wr;
        tick();
        chk("sweep_done_800", int'(s_done), 1);
        chk("sweep_pop_800", int'(s_pop), 1);
        chk("sweep_clearing_800", int'(s_clearing), 0);
        repeat (49) tick();
        chk("budget_pops_0", n_wr - base, 5);

        // Display priority and per-blanking budget
        for (int k = 0; k < 4; k++) begin
            fb.display_on = 1'b1;
            fb.hpos       = 10'd37;
            fb.vpos       = 10'd12;
            repeat (10) begin
                tick();
                chk("prio_pop", int'(s_pop), 0);
            end
            chk("prio_h", int'(s_h), 37);
            chk("prio_v", int'(s_v), 12);
            fb.display_on = 1'b0;
            head_h = (fifo_q.size() != 0) ? int'(fifo_q[0].h) : 0;
            base   = n_wr;
            tick();
            if (k < 3) begin
                chk("blank_first_pop", int'(s_pop), 1);
                chk("blank_head_h", int'(s_h), head_h);
            end
            repeat (49) tick();
            chk("budget_pops", n_wr - base, (k < 3) ? 5 : 0);
        end
        chk("drain_empty", exp_q.size(), 0);

        // Clear sweep paused by active video
        fb.clear_req = 1'b1;
        tick();
        fb.clear_req = 1'b0;
        low_seen = 0;
        got_done = 1'b0;
        for (int cyc = 0; cyc < 2000 && !got_done; cyc++) begin
            fb.display_on = ((cyc / 100) % 2) == 1;
            tick();
            if (s_done) begin
                got_done = 1'b1;
                chk("pause_done_at", low_seen, 800);
                chk("pause_done_cyc", cyc, 1500);
            end else begin
                chk("pause_clearing", int'(s_clearing), 1);
                if (!fb.display_on) begin
                    chk("pause_addr", int'(s_addr), low_seen);
                    chk("pause_clr", int'(s_clr), 1);
                    low_seen++;
                end else begin
                    chk("pause_clr_video", int'(s_clr), 0);
                end
            end
        end
        if (!got_done) chk("pause_timeout", 0, 1);
        fb.display_on = 1'b0;

        // Restart at 300 and at the terminal address
        fb.clear_req = 1'b1;
        tick();
        fb.clear_req = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            chk("rs1_addr", int'(s_addr), i);
            chk("rs1_done", int'(s_done), 0);
        end
        fb.clear_req = 1'b1;
        tick();
        chk("rs1_addr300", int'(s_addr), 300);
        fb.clear_req = 1'b0;
        for (int i = 0; i < 799; i++) begin
            tick();
            chk("rs2_addr", int'(s_addr), i);
            chk("rs2_done", int'(s_done), 0);
        end
        fb.clear_req = 1'b1;
        tick();
        chk("rs2_addr799", int'(s_addr), 799);
        fb.clear_req = 1'b0;
        tick();
        chk("rs3_nodone", int'(s_done), 0);
        chk("rs3_clearing", int'(s_clearing), 1);
        chk("rs3_addr0", int'(s_addr), 0);
        for (int i = 1; i < 800; i++) begin
            tick();
            chk("rs3_addr", int'(s_addr), i);
            chk("rs3_done", int'(s_done), 0);
        end
        tick();
        chk("rs3_done_end", int'(s_done), 1);
        chk("rs3_run", int'(s_clearing), 0);

        // Asynchronous reset mid-drain
        push(3);
        tick();
        chk("ar_first_pop", int'(s_pop), 1);
        #1;
        chk("ar_live_pop", int'(fb.fifo_pop), 1);
        reset_n = 1'b0;
        #1;
        chk("ar_pop", int'(fb.fifo_pop), 0);
        chk("ar_we", int'(fb.fb_we), 0);
        chk("ar_clearing", int'(fb.clearing), 1);
        chk("ar_addr", int'(fb.fb_clr_addr), 0);
        chk("ar_done", int'(fb.clear_done), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 800; i++) begin
            tick();
            chk("ar_sweep_addr", int'(s_addr), i);
            chk("ar_sweep_pop", int'(s_pop), 0);
        end
        tick();
        chk("ar_done_800", int'(s_done), 1);
        repeat (5) tick();
        chk("ar_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/fb_access_sched.md
# fb_access_sched

Schedules all accesses to the shared framebuffer port. The display scan always has priority while `display_on` is high. In blanking, the block either runs a memory-clear sweep or drains the pixel-write FIFO into the framebuffer, with an optional per-blanking write budget. It sits between the VGA timing generator, the ROM/brush write FIFO and `RGBMemory_top`, and replaces the ad-hoc position mux, FIFO-pop logic and `memsyncreset`.

## Interface
- `HPOS_WIDTH`, 10, width of horizontal position buses
- `VPOS_WIDTH`, 10, width of vertical position buses
- `ADDR_WIDTH`, 10, clear-sweep address width; must satisfy 2^ADDR_WIDTH >= RAMLENGTH
- `RAMLENGTH`, 800, number of framebuffer words swept by a clear
- `POP_LIMIT`, 0, maximum FIFO writes per blanking interval; 0 means unlimited
- `clk` in 1, pixel clock (PLL output)
- `reset_n` in 1, asynchronous, active-low reset
- `clear_req` in 1, single-cycle request to start or restart a clear sweep
- `display_on` in 1, active-video flag from the VGA timing generator
- `hpos` in HPOS_WIDTH, scan horizontal position
- `vpos` in VPOS_WIDTH, scan vertical position
- `fifo_empty` in 1, write FIFO empty; the FIFO is first-word-fall-through
- `fifo_hpos` in HPOS_WIDTH, head-of-FIFO horizontal position
- `fifo_vpos` in VPOS_WIDTH, head-of-FIFO vertical position
- `fifo_rgb` in 3, head-of-FIFO pixel
- `fifo_pop` out 1, pops the FIFO head; asserted in the same cycle as `fb_we`
- `fb_hpos` out HPOS_WIDTH, framebuffer horizontal position
- `fb_vpos` out VPOS_WIDTH, framebuffer vertical position
- `fb_rgb` out 3, framebuffer write pixel
- `fb_we` out 1, pixel write strobe
- `fb_clr` out 1, clear-write strobe for address `fb_clr_addr`
- `fb_clr_addr` out ADDR_WIDTH, clear-sweep address
- `clearing` out 1, high while in CLEAR
- `clear_done` out 1, one-cycle pulse after the final clear write

## Operation
- **States.** CLEAR and RUN. Reset enters CLEAR with `clr_cnt`=0, `pop_cnt`=0 and `clear_done`=0.
- **Reset values of outputs.**
  - `clearing`=1 and `fb_clr_addr`=0.
  - `fb_clr` = !`display_on`.
  - `fifo_pop`=0, `fb_we`=0 and `clear_done`=0.
  - Position outputs follow the mux rule below.
- **Position mux.** Combinational.
  - `display_on`=1: `fb_hpos`/`fb_vpos` = `hpos`/`vpos`.
  - Otherwise: `fb_hpos`/`fb_vpos` = `fifo_hpos`/`fifo_vpos`.
  - `fb_rgb` = `fifo_rgb` at all times.
- **CLEAR.**
  - `fb_clr` = !`display_on`; `fb_clr_addr` = `clr_cnt`.
  - `clr_cnt` increments only on cycles with `fb_clr`=1, so the sweep pauses during active video.
  - `fifo_pop` and `fb_we` are held at 0; the FIFO backs up and may fill, and producers must honour full.
- **CLEAR exit.** When `fb_clr`=1 and `clr_cnt`=RAMLENGTH-1:
  - next state is RUN and `clr_cnt` goes to 0;
  - `clear_done`=1 for exactly the following cycle.
- **RUN.** `fifo_pop` = `fb_we` = !`display_on` & !`fifo_empty` & budget_ok.
  - budget_ok = (POP_LIMIT==0) | (`pop_cnt` < POP_LIMIT).
- **`pop_cnt` counter.**
  - Increments on each pop.
  - Clears on any cycle with `display_on`=1, i.e. once per blanking interval.
  - Saturates at POP_LIMIT.
  - Width is $clog2(POP_LIMIT+1), minimum 1.
- **`clear_req` in RUN.** Next state is CLEAR with `clr_cnt`=0. A pop in the same cycle still completes.
- **`clear_req` in CLEAR.** Restarts the sweep: `clr_cnt`=0. This applies even on the terminal cycle, in which case no `clear_done` is produced and the state stays CLEAR.
- **Mutual exclusion.** `fb_we` and `fb_clr` are never both 1. Neither is ever 1 while `display_on`=1.
- **Asynchronous reset mid-sweep or mid-drain.** Immediate return to the reset values. In-flight FIFO contents are untouched; the FIFO has its own reset.

## Timing
- `fifo_pop`, `fb_we`, `fb_clr` and the position mux are combinational from inputs plus registered state, with zero latency.
- The FIFO head is written in the same cycle it is popped; the FIFO advances on the next edge.
- State, `clr_cnt`, `pop_cnt` and `clear_done` are registered on the rising edge of `clk`.
- Clear duration is RAMLENGTH cycles with `display_on`=0, plus any active-video cycles in between.
- From a reset release with `display_on` held 0: addresses 0..799 occupy cycles 0..799, and `clear_done` is high in cycle 800.
- A `clear_req` sampled at edge N gives `fb_clr_addr`=0 from cycle N+1.

## Test plan
- **Reset sweep.** `display_on`=0 and FIFO non-empty from reset release → `fb_clr` high for 800 consecutive cycles with addresses 0..799 and `fifo_pop`=0 → `clear_done` pulses in cycle 800 → `fifo_pop` goes high in cycle 800.
- **Sweep paused by video.** Toggle `display_on` 100 cycles low / 100 cycles high → `fb_clr` is gated, addresses stay contiguous with no skips, and `clear_done` occurs after exactly 800 low cycles.
- **Display priority in RUN.** `display_on`=1 with `hpos`=37, `vpos`=12 and FIFO non-empty → `fb_hpos`=37, `fb_vpos`=12, `fifo_pop`=0. When `display_on` drops, `fb_hpos`/`fb_vpos` switch to the FIFO head and `fifo_pop`=1 in the same cycle.
- **Budget.** POP_LIMIT=5 with 20 queued words and a 50-cycle blanking interval → exactly 5 pops. The next blanking interval gives 5 more, until `fifo_empty`.
- **Restart.** `clear_req` at `clr_cnt`=300, then again at the terminal cycle (799) → sweep restarts at 0 both times, no `clear_done` until a full uninterrupted 800-write sweep completes.
- **Asynchronous reset.** Assert `reset_n`=0 mid-drain → `fifo_pop`/`fb_we` drop to 0 immediately, `clearing`=1, `fb_clr_addr`=0.
